button_conditioner: RTL and testbench

Input-side counterpart to the board's LED drivers. Takes raw asynchronous push-button inputs (Cmod A7 btn[1:0]) and produces clean, synchronous, debounced button levels plus one-cycle press and release pulses in the sysclk domain. Control logic (LED pattern select, SPI test triggers) consumes these outputs instead of raw pins.

---
 rtl/btn_pkg.sv | 15 +
 rtl/btn_debounce_ch.sv | 111 +++++++++++
 rtl/button_conditioner.sv | 34 +++
 tb/tb_button_conditioner.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared timing constants for the push-button conditioner.
package btn_pkg;

    localparam int CLK_HZ      = 12000000;
    localparam int DEBOUNCE_MS = 10;
    localparam int LONG_MS     = 1000;

    function automatic int ms_to_cycles(input int ms);
        return (CLK_HZ / 1000) * ms;
    endfunction

    localparam int DEBOUNCE_CYCLES_DEF = ms_to_cycles(DEBOUNCE_MS);
    localparam int LONG_CYCLES_DEF     = ms_to_cycles(LONG_MS);

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchronizer, debounce counter, press/release pulses,
// and a long-press pulse when BTN_LONG_PRESS_EN is defined.
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int LONG_CYCLES     = LONG_CYCLES_DEF
) (
    input  logic sysclk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic long_o
);

    if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES < 2) begin : g_param_check
        $error("btn_debounce_ch: DEBOUNCE_CYCLES and LONG_CYCLES must be >= 2");
    end

    localparam int DCW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DCW-1:0] DMAX = DCW'(DEBOUNCE_CYCLES - 1);

    logic           s1_q, s2_q;
    logic           level_q, level_d;
    logic           press_q, press_d;
    logic           release_q, release_d;
    logic [DCW-1:0] cnt_q, cnt_d;

    always_comb begin
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        cnt_d     = '0;
        if (s2_q != level_q) begin
            if (cnt_q == DMAX) begin
                level_d   = s2_q;
                press_d   = s2_q;
                release_d = ~s2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge sysclk_i) begin
        if (rst_i) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            s1_q      <= raw_i;
            s2_q      <= s1_q;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            cnt_q     <= cnt_d;
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;

`ifdef BTN_LONG_PRESS_EN
    localparam int LCW = $clog2(LONG_CYCLES);
    localparam logic [LCW-1:0] LMAX = LCW'(LONG_CYCLES - 1);

    logic [LCW-1:0] hold_q, hold_d;
    logic           fired_q, fired_d;
    logic           long_q, long_d;

    // fired_q latches the one pulse per press; the saturated count alone would re-fire
    always_comb begin
        hold_d  = '0;
        fired_d = 1'b0;
        long_d  = 1'b0;
        if (level_q) begin
            hold_d  = hold_q;
            fired_d = fired_q;
            if (hold_q != LMAX) begin
                hold_d = hold_q + 1'b1;
            end else if (!fired_q) begin
                long_d  = 1'b1;
                fired_d = 1'b1;
            end
        end
    end

    always_ff @(posedge sysclk_i) begin
        if (rst_i) begin
            hold_q  <= '0;
            fired_q <= 1'b0;
            long_q  <= 1'b0;
        end else begin
            hold_q  <= hold_d;
            fired_q <= fired_d;
            long_q  <= long_d;
        end
    end

    assign long_o = long_q;
`else
    assign long_o = 1'b0;
`endif

endmodule

// File: rtl/button_conditioner.sv
// Debounced push-button conditioner: fans N_BTN independent channels out.
// Optional long-press pulse enabled by defining BTN_LONG_PRESS_EN.
module button_conditioner
    import btn_pkg::*;
#(
    parameter int N_BTN           = 2,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int LONG_CYCLES     = LONG_CYCLES_DEF
) (
    input  logic             sysclk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_long
);

    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .LONG_CYCLES    (LONG_CYCLES)
        ) u_ch (
            .sysclk_i (sysclk),
            .rst_i    (rst),
            .raw_i    (btn_raw[g]),
            .level_o  (btn_level[g]),
            .press_o  (btn_press[g]),
            .release_o(btn_release[g]),
            .long_o   (btn_long[g])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: reference model pushes expected outputs
// per edge, a negedge monitor pops and compares.
module tb_button_conditioner;

    localparam int N = 2;
    localparam int D = 4;
    localparam int L = 20;

    logic         sysclk = 1'b0;
    logic         rst;
    logic [N-1:0] btn_raw;
    logic [N-1:0] btn_level, btn_press, btn_release, btn_long;

    always #5 sysclk = ~sysclk;

    button_conditioner #(
        .N_BTN          (N),
        .DEBOUNCE_CYCLES(D),
        .LONG_CYCLES    (L)
    ) dut (
        .sysclk     (sysclk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_long   (btn_long)
    );

    typedef struct packed {
        logic [N-1:0] level;
        logic [N-1:0] press;
        logic [N-1:0] rel;
        logic [N-1:0] lng;
        int           edge_no;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: raw is seen two edges late; an input is accepted once it has
    // disagreed with the level for D consecutive edges; long fires L edges after press.
    int   edge_n = 0;
    logic m_p1[N], m_p2[N], m_lvl[N];
    int   m_run[N], m_press_t[N];

    initial begin
        for (int c = 0; c < N; c++) begin
            m_p1[c] = 1'b0; m_p2[c] = 1'b0; m_lvl[c] = 1'b0;
            m_run[c] = 0; m_press_t[c] = 0;
        end
    end

    always @(posedge sysclk) begin
        exp_t e;
        logic s2;
        edge_n = edge_n + 1;
        e = '0;
        e.edge_no = edge_n;
        for (int c = 0; c < N; c++) begin
            if (rst) begin
                m_p1[c] = 1'b0; m_p2[c] = 1'b0; m_lvl[c] = 1'b0; m_run[c] = 0;
            end else begin
                s2 = m_p2[c];
                m_p2[c] = m_p1[c];
                m_p1[c] = btn_raw[c];
`ifdef BTN_LONG_PRESS_EN
                if (m_lvl[c] && (edge_n - m_press_t[c] == L)) e.lng[c] = 1'b1;
`endif
                if (s2 != m_lvl[c]) begin
                    m_run[c] = m_run[c] + 1;
                    if (m_run[c] == D) begin
                        m_lvl[c] = s2;
                        m_run[c] = 0;
                        if (s2) begin
                            e.press[c] = 1'b1;
                            m_press_t[c] = edge_n;
                        end else begin
                            e.rel[c] = 1'b1;
                        end
                    end
                end else begin
                    m_run[c] = 0;
                end
            end
            e.level[c] = m_lvl[c];
        end
        exp_q.push_back(e);
    end

    always @(negedge sysclk) begin
        exp_t e;
        n_checks = n_checks + 1;
        if (exp_q.size() == 0) begin
            $display("FAIL scoreboard_empty: DUT output present but no expectation queued");
        end else begin
            e = exp_q.pop_front();
            if ({btn_level, btn_press, btn_release, btn_long} === {e.level, e.press, e.rel, e.lng})
                n_pass = n_pass + 1;
            else
                $display("FAIL outputs edge %0d: got lvl=%b prs=%b rel=%b lng=%b, want lvl=%b prs=%b rel=%b lng=%b",
                         e.edge_no, btn_level, btn_press, btn_release, btn_long,
                         e.level, e.press, e.rel, e.lng);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge sysclk);
    endtask

    initial begin
        rst = 1'b1;
        btn_raw = '0;
        idle(3);
        rst = 1'b0;
        idle(20);

        btn_raw[0] = 1'b1;                      // clean press on channel 0
        idle(10);

        for (int i = 0; i < 4; i++) begin       // bounce on channel 1
            btn_raw[1] = (i % 2 == 0);
            idle(2);
        end
        btn_raw[1] = 1'b1;
        idle(12);

        btn_raw = '0;                           // simultaneous release
        idle(12);

        btn_raw = 2'b01;                        // reset on the 2nd mismatch edge
        idle(3);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(12);
        btn_raw = '0;
        idle(12);

        for (int k = 0; k < 2; k++) begin       // long press, twice
            btn_raw[0] = 1'b1;
            idle(40);
            btn_raw[0] = 1'b0;
            idle(12);
        end

        for (int i = 0; i < 400; i++) begin
            btn_raw = N'($urandom);
            if ($urandom_range(0, 49) == 0) begin
                rst = 1'b1;
                idle(1);
                rst = 1'b0;
            end
            if ($urandom_range(0, 9) == 0) idle(int'($urandom_range(20, 35)));
            else                           idle(int'($urandom_range(1, 8)));
        end

        btn_raw = '0;
        idle(40);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
